// File: rtl/uart_rx_ctrl.sv
// UART receive bit-timing controller: synchronises rx_in, qualifies the start bit,
// samples each bit at mid-bit, drives the shift register and assembles the byte.
module uart_rx_ctrl #(
  parameter int unsigned BIT_CYCLES = 434,
  parameter bit          PARITY_EN  = 1'b0,
  parameter bit          PARITY_ODD = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_in,
  output logic       shift_en,
  output logic       ser_bit,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       parity_err,
  output logic       busy
);

  localparam int unsigned   CW        = $clog2(BIT_CYCLES);
  localparam logic [CW-1:0] HALF_LAST = CW'(BIT_CYCLES / 2 - 1);
  localparam logic [CW-1:0] FULL_LAST = CW'(BIT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_WAIT_HIGH
  } state_e;

  logic          rx_meta_q;
  logic          rxs_q;
  state_e        state_q,    state_d;
  logic [CW-1:0] cyc_cnt_q,  cyc_cnt_d;
  logic [3:0]    bit_idx_q,  bit_idx_d;
  logic [7:0]    shadow_q,   shadow_d;
  logic          par_flag_q, par_flag_d;
  logic          stop_bit_q, stop_bit_d;
  logic          done_q,     done_d;
  logic          shift_en_q, shift_en_d;
  logic          ser_bit_q,  ser_bit_d;
  logic [7:0]    rx_data_q;
  logic          rx_valid_q;
  logic          frame_err_q;
  logic          parity_err_q;

  // Two-flop synchroniser; idles high so reset must not fake a start bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta_q <= 1'b1;
      rxs_q     <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments in clocked blocks so every flop samples
      // pre-edge values; blocking here would collapse the synchroniser to one stage.
      rx_meta_q <= rx_in;
      rxs_q     <= rx_meta_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      cyc_cnt_q  <= '0;
      bit_idx_q  <= '0;
      // NOTE: the byte shadow is reset as well, so rx_data can never expose an
      // unknown value even if a consumer samples it before the first frame.
      shadow_q   <= '0;
      par_flag_q <= 1'b0;
      stop_bit_q <= 1'b0;
      done_q     <= 1'b0;
      shift_en_q <= 1'b0;
      ser_bit_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cyc_cnt_q  <= cyc_cnt_d;
      bit_idx_q  <= bit_idx_d;
      shadow_q   <= shadow_d;
      par_flag_q <= par_flag_d;
      stop_bit_q <= stop_bit_d;
      done_q     <= done_d;
      shift_en_q <= shift_en_d;
      ser_bit_q  <= ser_bit_d;
    end
  end

  always_comb begin
    // NOTE: every variable gets a default before the case so no path can
    // leave one unassigned and infer a latch.
    state_d    = state_q;
    cyc_cnt_d  = cyc_cnt_q;
    bit_idx_d  = bit_idx_q;
    shadow_d   = shadow_q;
    par_flag_d = par_flag_q;
    stop_bit_d = stop_bit_q;
    done_d     = 1'b0;
    shift_en_d = 1'b0;
    ser_bit_d  = ser_bit_q;

    unique case (state_q)
      S_IDLE: begin
        if (!rxs_q) begin
          state_d   = S_START;
          cyc_cnt_d = '0;
        end
      end

      S_START: begin
        if (cyc_cnt_q == HALF_LAST) begin
          if (!rxs_q) begin
            shift_en_d = 1'b1;
            ser_bit_d  = 1'b0;
            cyc_cnt_d  = '0;
            bit_idx_d  = '0;
            par_flag_d = 1'b0;
            state_d    = S_DATA;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cyc_cnt_d = cyc_cnt_q + 1'b1;
        end
      end

      S_DATA: begin
        if (cyc_cnt_q == FULL_LAST) begin
          shift_en_d                = 1'b1;
          ser_bit_d                 = rxs_q;
          shadow_d[bit_idx_q[2:0]]  = rxs_q;
          cyc_cnt_d                 = '0;
          if (bit_idx_q == 4'd7) begin
            state_d = PARITY_EN ? S_PARITY : S_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 4'd1;
          end
        end else begin
          cyc_cnt_d = cyc_cnt_q + 1'b1;
        end
      end

      S_PARITY: begin
        if (cyc_cnt_q == FULL_LAST) begin
          shift_en_d = 1'b1;
          ser_bit_d  = rxs_q;
          par_flag_d = (rxs_q != (^shadow_q ^ PARITY_ODD));
          cyc_cnt_d  = '0;
          state_d    = S_STOP;
        end else begin
          cyc_cnt_d = cyc_cnt_q + 1'b1;
        end
      end

      // Leaving at the stop mid-sample lets a back-to-back start bit be caught.
      S_STOP: begin
        if (cyc_cnt_q == FULL_LAST) begin
          shift_en_d = 1'b1;
          ser_bit_d  = rxs_q;
          stop_bit_d = rxs_q;
          done_d     = 1'b1;
          cyc_cnt_d  = '0;
          state_d    = rxs_q ? S_IDLE : S_WAIT_HIGH;
        end else begin
          cyc_cnt_d = cyc_cnt_q + 1'b1;
        end
      end

      S_WAIT_HIGH: begin
        if (rxs_q) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Result register: published one cycle after the stop-bit shift pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      rx_valid_q <= done_q;
      if (done_q) begin
        rx_data_q    <= shadow_q;
        frame_err_q  <= ~stop_bit_q;
        parity_err_q <= PARITY_EN ? par_flag_q : 1'b0;
      end
    end
  end

  assign shift_en   = shift_en_q;
  assign ser_bit    = ser_bit_q;
  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign frame_err  = frame_err_q;
  assign parity_err = parity_err_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: lane A is 8N1, lane B adds even parity; both use 16 cycles/bit.
module tb_uart_rx_ctrl;

  localparam int BC      = 16;
  localparam bit PAR_ODD = 1'b0;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx_a = 1'b1, rx_b = 1'b1;
  logic       se_a, sb_a, rv_a, fe_a, pe_a, busy_a;
  logic       se_b, sb_b, rv_b, fe_b, pe_b, busy_b;
  logic [7:0] rd_a, rd_b;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct { int c; logic b; } shift_t;
  typedef struct { int c; logic [7:0] d; logic fe; logic pe; } frame_t;
  typedef struct { logic [7:0] d; logic fe; logic pe; int nb; } exp_t;

  shift_t sh_a[$], sh_b[$];
  frame_t vq_a[$], vq_b[$];
  bit     exp_bits[$];
  exp_t   exp_f[$];

  uart_rx_ctrl #(.BIT_CYCLES(BC), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) dut_a (
    .clk(clk), .rst(rst), .rx_in(rx_a), .shift_en(se_a), .ser_bit(sb_a),
    .rx_data(rd_a), .rx_valid(rv_a), .frame_err(fe_a), .parity_err(pe_a), .busy(busy_a)
  );

  uart_rx_ctrl #(.BIT_CYCLES(BC), .PARITY_EN(1'b1), .PARITY_ODD(PAR_ODD)) dut_b (
    .clk(clk), .rst(rst), .rx_in(rx_b), .shift_en(se_b), .ser_bit(sb_b),
    .rx_data(rd_b), .rx_valid(rv_b), .frame_err(fe_b), .parity_err(pe_b), .busy(busy_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic shift_t mk_shift(input int c, input logic b);
    shift_t s;
    s.c = c;
    s.b = b;
    return s;
  endfunction

  function automatic frame_t mk_frame(input int c, input logic [7:0] d, input logic fe, input logic pe);
    frame_t f;
    f.c  = c;
    f.d  = d;
    f.fe = fe;
    f.pe = pe;
    return f;
  endfunction

  // Record every shift pulse and every completed frame, sampled mid-cycle.
  always @(negedge clk) begin
    if (se_a) sh_a.push_back(mk_shift(cyc, sb_a));
    if (se_b) sh_b.push_back(mk_shift(cyc, sb_b));
    if (rv_a) vq_a.push_back(mk_frame(cyc, rd_a, fe_a, pe_a));
    if (rv_b) vq_b.push_back(mk_frame(cyc, rd_b, fe_b, pe_b));
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_line(input int lane, input logic b);
    if (lane == 0) rx_a = b;
    else           rx_b = b;
  endtask

  function automatic logic get_busy(input int lane);
    return (lane == 0) ? busy_a : busy_b;
  endfunction

  task automatic clear_all();
    sh_a.delete(); sh_b.delete();
    vq_a.delete(); vq_b.delete();
    exp_bits.delete(); exp_f.delete();
  endtask

  // Reference model: the line bits themselves are the expected samples.
  task automatic drive_frame(input int lane, input logic [7:0] d, input bit has_par,
                             input bit par, input bit stop);
    bit   fb[$];
    exp_t e;
    fb.push_back(1'b0);
    for (int i = 0; i < 8; i++) fb.push_back(d[i]);
    if (has_par) fb.push_back(par);
    fb.push_back(stop);
    e.d  = d;
    e.fe = !stop;
    e.pe = has_par && (par != ((^d) ^ PAR_ODD));
    e.nb = fb.size();
    exp_f.push_back(e);
    foreach (fb[i]) exp_bits.push_back(fb[i]);
    foreach (fb[i]) begin
      set_line(lane, fb[i]);
      tick(BC);
    end
  endtask

  task automatic wait_idle(input int lane, input string name);
    int n = 0;
    while (get_busy(lane) && n < 200) begin
      tick(1);
      n++;
    end
    total++;
    if (get_busy(lane) !== 1'b0) begin
      bad++;
      $display("FAIL %s idle_timeout: busy=%b want 0 after %0d cycles", name, get_busy(lane), n);
    end
  endtask

  task automatic expect_all(input int lane, input string name);
    shift_t     sh[$];
    frame_t     vq[$];
    int         idx;
    int         base;
    bit         sh_ok;
    logic [7:0] rd_now;
    if (lane == 0) begin sh = sh_a; vq = vq_a; rd_now = rd_a; end
    else           begin sh = sh_b; vq = vq_b; rd_now = rd_b; end

    total++;
    sh_ok = (sh.size() == exp_bits.size());
    if (!sh_ok) begin
      bad++;
      $display("FAIL %s shift_count: got %0d want %0d", name, sh.size(), exp_bits.size());
    end else begin
      total++;
      idx = -1;
      foreach (sh[i]) if (idx < 0 && sh[i].b !== exp_bits[i]) idx = i;
      if (idx >= 0) begin
        bad++;
        $display("FAIL %s ser_bit[%0d]: got %b want %b", name, idx, sh[idx].b, exp_bits[idx]);
      end
      total++;
      idx  = -1;
      base = 0;
      foreach (exp_f[k]) begin
        for (int j = 1; j < exp_f[k].nb; j++)
          if (idx < 0 && (sh[base+j].c - sh[base+j-1].c) != BC) idx = base + j;
        base += exp_f[k].nb;
      end
      if (idx >= 0) begin
        bad++;
        $display("FAIL %s shift_spacing[%0d]: got %0d want %0d", name, idx,
                 sh[idx].c - sh[idx-1].c, BC);
      end
    end

    total++;
    if (vq.size() != exp_f.size()) begin
      bad++;
      $display("FAIL %s valid_count: got %0d want %0d", name, vq.size(), exp_f.size());
    end else begin
      base = 0;
      foreach (exp_f[k]) begin
        base += exp_f[k].nb;
        total += 3;
        if (vq[k].d !== exp_f[k].d) begin
          bad++;
          $display("FAIL %s rx_data[%0d]: got %02h want %02h", name, k, vq[k].d, exp_f[k].d);
        end
        if (vq[k].fe !== exp_f[k].fe) begin
          bad++;
          $display("FAIL %s frame_err[%0d]: got %b want %b", name, k, vq[k].fe, exp_f[k].fe);
        end
        if (vq[k].pe !== exp_f[k].pe) begin
          bad++;
          $display("FAIL %s parity_err[%0d]: got %b want %b", name, k, vq[k].pe, exp_f[k].pe);
        end
        if (sh_ok) begin
          total++;
          if (vq[k].c !== sh[base-1].c + 1) begin
            bad++;
            $display("FAIL %s valid_latency[%0d]: got cycle %0d want %0d", name, k,
                     vq[k].c, sh[base-1].c + 1);
          end
        end
      end
      if (exp_f.size() > 0) begin
        total++;
        if (rd_now !== exp_f[exp_f.size()-1].d) begin
          bad++;
          $display("FAIL %s rx_data_hold: got %02h want %02h", name, rd_now,
                   exp_f[exp_f.size()-1].d);
        end
      end
    end
  endtask

  task automatic test_reset();
    total += 2;
    if ({se_a, sb_a, rd_a, rv_a, fe_a, pe_a, busy_a} !== 14'h0) begin
      bad++;
      $display("FAIL reset_a: got %h want 0", {se_a, sb_a, rd_a, rv_a, fe_a, pe_a, busy_a});
    end
    if ({se_b, sb_b, rd_b, rv_b, fe_b, pe_b, busy_b} !== 14'h0) begin
      bad++;
      $display("FAIL reset_b: got %h want 0", {se_b, sb_b, rd_b, rv_b, fe_b, pe_b, busy_b});
    end
  endtask

  task automatic test_frame_a5();
    clear_all();
    drive_frame(0, 8'hA5, 1'b0, 1'b0, 1'b1);
    tick(BC);
    wait_idle(0, "a5");
    expect_all(0, "a5");
  endtask

  task automatic test_glitch();
    bit seen = 1'b0;
    clear_all();
    rx_a = 1'b0;
    for (int i = 0; i < 4; i++) begin tick(1); seen |= busy_a; end
    rx_a = 1'b1;
    for (int i = 0; i < 11; i++) begin tick(1); seen |= busy_a; end
    total += 4;
    if (seen !== 1'b1) begin bad++; $display("FAIL glitch_busy_seen: got %b want 1", seen); end
    if (busy_a !== 1'b0) begin bad++; $display("FAIL glitch_busy_end: got %b want 0", busy_a); end
    if (sh_a.size() != 0) begin bad++; $display("FAIL glitch_shift: got %0d want 0", sh_a.size()); end
    if (vq_a.size() != 0) begin bad++; $display("FAIL glitch_valid: got %0d want 0", vq_a.size()); end
  endtask

  task automatic test_break();
    clear_all();
    drive_frame(0, 8'h55, 1'b0, 1'b0, 1'b0);
    tick(200);
    total++;
    if (busy_a !== 1'b1) begin bad++; $display("FAIL break_busy: got %b want 1", busy_a); end
    expect_all(0, "break");
    rx_a = 1'b1;
    tick(BC);
    wait_idle(0, "break_release");
    clear_all();
    drive_frame(0, 8'h12, 1'b0, 1'b0, 1'b1);
    tick(BC);
    expect_all(0, "after_break");
  endtask

  task automatic test_parity();
    clear_all();
    drive_frame(1, 8'h03, 1'b1, 1'b0, 1'b1);
    tick(BC);
    expect_all(1, "parity_good");
    clear_all();
    drive_frame(1, 8'h03, 1'b1, 1'b1, 1'b1);
    tick(BC);
    expect_all(1, "parity_bad");
  endtask

  task automatic test_random();
    clear_all();
    for (int k = 0; k < 6; k++) begin
      drive_frame(0, 8'($urandom), 1'b0, 1'b0, 1'b1);
      tick($urandom_range(0, 24));
    end
    tick(BC);
    wait_idle(0, "rand_a");
    expect_all(0, "rand_a");
    clear_all();
    for (int k = 0; k < 6; k++) begin
      drive_frame(1, 8'($urandom), 1'b1, 1'($urandom_range(0, 1)), 1'b1);
      tick($urandom_range(0, 24));
    end
    tick(BC);
    wait_idle(1, "rand_b");
    expect_all(1, "rand_b");
  endtask

  task automatic test_reset_mid();
    logic [7:0] d = 8'hF0;
    clear_all();
    rx_a = 1'b0;
    tick(BC);
    for (int i = 0; i < 4; i++) begin rx_a = d[i]; tick(BC); end
    rx_a = d[4];
    tick(8);
    #2;
    rst  = 1'b0;
    rx_a = 1'b1;
    #1;
    total++;
    if ({se_a, sb_a, rd_a, rv_a, fe_a, pe_a, busy_a} !== 14'h0) begin
      bad++;
      $display("FAIL reset_mid_outputs: got %h want 0", {se_a, sb_a, rd_a, rv_a, fe_a, pe_a, busy_a});
    end
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    tick(120);
    total += 2;
    if (vq_a.size() != 0) begin bad++; $display("FAIL reset_mid_valid: got %0d want 0", vq_a.size()); end
    if (busy_a !== 1'b0) begin bad++; $display("FAIL reset_mid_busy: got %b want 0", busy_a); end
    clear_all();
    drive_frame(0, 8'h3C, 1'b0, 1'b0, 1'b1);
    tick(BC);
    expect_all(0, "after_reset");
  endtask

  task automatic test_back_to_back();
    clear_all();
    drive_frame(0, 8'h00, 1'b0, 1'b0, 1'b1);
    drive_frame(0, 8'hFF, 1'b0, 1'b0, 1'b1);
    tick(BC);
    wait_idle(0, "b2b");
    expect_all(0, "b2b");
    if (vq_a.size() == 2) begin
      total++;
      if (vq_a[1].c - vq_a[0].c != 10 * BC) begin
        bad++;
        $display("FAIL b2b_gap: got %0d want %0d", vq_a[1].c - vq_a[0].c, 10 * BC);
      end
    end
  endtask

  initial begin
    tick(3);
    test_reset();
    rst = 1'b1;
    tick(4);
    test_frame_a5();
    test_glitch();
    test_break();
    test_parity();
    test_random();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
